m2s_fifo_write_arbiter: RTL and testbench
=========================================

# m2s_fifo_write_arbiter

Round-robin arbiter that shares the single Avalon-MM write slave of the memory-to-stream FIFO between several Avalon-MM write masters, e.g. the CPU's data master and the sample-loader DMA. Sits directly in front of the FIFO's write slave. Grants one requester at a time for a bounded burst and forwards the FIFO's backpressure to it. Every word accepted by the FIFO is attributed to exactly one requester.

## Interface
Parameters:
- NUM_REQ, 2: number of requesting masters (2..8).
- DATA_W, 32: write data width, equal to the FIFO width.
- BURST_MAX, 8: maximum words accepted per grant before forced re-arbitration (1..255).

Ports:
- clock  in  1  single clock; all logic is rising-edge.
- reset  in  1  synchronous, active-high reset.
- req_write  in  NUM_REQ  per-requester write strobe.
- req_writedata  in  NUM_REQ*DATA_W  requester i occupies bits [i*DATA_W +: DATA_W].
- req_waitrequest  out  NUM_REQ  per-requester stall.
- fifo_address  out  1  constant 0 (FIFO data register).
- fifo_write  out  1  write strobe to the FIFO slave.
- fifo_writedata  out  DATA_W  data to the FIFO slave.
- fifo_waitrequest  in  1  FIFO full, or FIFO in reset.
- grant_valid  out  1  high in GRANTED.
- grant_id  out  clog2(NUM_REQ)  index of the current grantee, valid with grant_valid.

## Operation
- State machine: IDLE, GRANTED.
- IDLE:
  - All req_waitrequest = 1, fifo_write = 0.
  - If any req_write is high, pick the first asserted index scanning upward, with wrap, from rr_ptr.
  - Register that index as grant_id, clear burst_cnt, go to GRANTED.
  - If no req_write is high, stay in IDLE.
- GRANTED, for grantee g:
  - fifo_write = req_write[g].
  - fifo_writedata = req_writedata[g].
  - req_waitrequest[g] = fifo_waitrequest.
  - All other req_waitrequest = 1.
  - Accept condition: req_write[g] & ~fifo_waitrequest. Each accept increments burst_cnt (width clog2(BURST_MAX+1), never wraps).
- Release from GRANTED to IDLE at the clock edge where either of these holds:
  - an accept makes burst_cnt reach BURST_MAX; or
  - req_write[g] is low (grantee paused).
- On release, rr_ptr <= (g+1) mod NUM_REQ. The released requester therefore has lowest priority next time.
- A stall (req_write[g] high, fifo_waitrequest high) holds the grant indefinitely and does not count.
- Simultaneous requests: the round-robin order from rr_ptr decides.
- New requests arriving during GRANTED wait in IDLE for the next arbitration.
- Reset:
  - state = IDLE, rr_ptr = 0, burst_cnt = 0, grant_id = 0, grant_valid = 0, fifo_write = 0.
  - All req_waitrequest = 1 while reset is high.
  - Reset mid-burst drops the grant. Words already accepted stay in the FIFO. The interrupted master sees waitrequest = 1 and retries.

## Timing
- Arbitration latency: a request first seen in IDLE at edge N gets grant_valid, and can be accepted, in cycle N+1.
- Data path in GRANTED is combinational: fifo_write, fifo_writedata and req_waitrequest[g] depend on the same cycle's inputs. There are no register stages and no extra data latency.
- One IDLE cycle between consecutive grants. Peak throughput: BURST_MAX words per BURST_MAX+1 cycles.
- fifo_waitrequest reaches req_waitrequest[g] in the same cycle (combinational).

## Structure
- Shared package m2s_arb_pkg holds:
  - the state enum (IDLE, GRANTED);
  - the function rr_pick(req, ptr) returning the next index.
- One sub-module, m2s_rr_picker: combinational round-robin priority picker (req vector, ptr → index, any). It is reusable by other shared slaves in the system.
- Top level holds the FSM, rr_ptr, burst_cnt and the output muxes.

## Test plan
- Single requester, no backpressure. NUM_REQ=2, BURST_MAX=8. Req0 holds write for 20 words 0x100..0x113. Expected:
  - grants of 8, 8, 4 words, one IDLE cycle between grants;
  - FIFO receives 0x100..0x113 in order, no duplicates.
- Contention. Req0 and req1 both write continuously from reset release. Expected:
  - grant_id sequence 0, 1, 0, 1;
  - 8 words per grant;
  - req_waitrequest of the non-grantee is 1 every cycle.
- Backpressure. fifo_waitrequest is high for 5 cycles in the middle of req1's burst. Expected:
  - req_waitrequest[1] follows it in the same cycle;
  - burst_cnt is frozen and the grant is held;
  - the held word is accepted exactly once when waitrequest drops.
- Early release. Req0 writes 3 words, then drops write. Expected:
  - release after 3 accepts, rr_ptr = 1;
  - a pending req1 is granted 2 cycles after req0 drops write.
- Reset mid-burst. Assert reset after 4 accepted words of req1. Expected:
  - next cycle: grant_valid = 0, fifo_write = 0, all req_waitrequest = 1, rr_ptr = 0;
  - after reset release with both requesting, req0 is granted first.
- Idle. No req_write for 50 cycles. Expected: state stays IDLE, fifo_write = 0 throughout.

Source files
------------

// File: rtl/m2s_arb_pkg.sv
// Shared definitions for the memory-to-stream FIFO write arbiter: FSM states and
// the round-robin pick function reused by other shared-slave arbiters.
package m2s_arb_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      GRANTED = 1'b1
   } arb_state_t;

   localparam int unsigned RR_MAX_REQ = 8;

   // First asserted index scanning upward from ptr with wrap over n requesters;
   // returns ptr when nothing is requesting.
   function automatic int unsigned rr_pick(input logic [RR_MAX_REQ-1:0] req,
                                           input int unsigned ptr,
                                           input int unsigned n);
      int unsigned idx;
      int unsigned sel;
      logic        found;
      sel   = ptr;
      found = 1'b0;
      for (int unsigned i = 0; i < RR_MAX_REQ; i++) begin
         idx = (ptr + i) % n;
         if (!found && (i < n) && (((req >> idx) & RR_MAX_REQ'(1)) != '0)) begin
            sel   = idx;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/m2s_rr_picker.sv
// Combinational round-robin priority picker: request vector and start pointer in,
// winning index and any-request flag out. No state, zero latency.
module m2s_rr_picker
   import m2s_arb_pkg::*;
#(
   parameter int unsigned NUM_REQ = 2,
   parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] i_req,
   input  logic [ID_W-1:0]    i_ptr,
   output logic [ID_W-1:0]    o_idx,
   output logic               o_any
);

   assign o_idx = ID_W'(rr_pick(RR_MAX_REQ'(i_req), 32'(i_ptr), NUM_REQ));
   assign o_any = |i_req;

endmodule

// File: rtl/m2s_fifo_write_arbiter.sv
// Round-robin arbiter sharing the M2S FIFO write slave between Avalon-MM write masters.
// One arbitration cycle per grant, combinational data/backpressure path while granted.
module m2s_fifo_write_arbiter
   import m2s_arb_pkg::*;
#(
   parameter  int unsigned NUM_REQ   = 2,
   parameter  int unsigned DATA_W    = 32,
   parameter  int unsigned BURST_MAX = 8,
   localparam int unsigned ID_W      = $clog2(NUM_REQ),
   localparam int unsigned CNT_W     = $clog2(BURST_MAX + 1)
) (
   input  logic                      i_clock,
   input  logic                      i_reset,
   input  logic [NUM_REQ-1:0]        i_req_write,
   input  logic [NUM_REQ*DATA_W-1:0] i_req_writedata,
   output logic [NUM_REQ-1:0]        o_req_waitrequest,
   output logic                      o_fifo_address,
   output logic                      o_fifo_write,
   output logic [DATA_W-1:0]         o_fifo_writedata,
   input  logic                      i_fifo_waitrequest,
   output logic                      o_grant_valid,
   output logic [ID_W-1:0]           o_grant_id
);

   arb_state_t        r_state;
   arb_state_t        w_state_nxt;
   logic [ID_W-1:0]   r_grant_id;
   logic [ID_W-1:0]   r_rr_ptr;
   logic [CNT_W-1:0]  r_burst_cnt;
   logic [ID_W-1:0]   w_pick_idx;
   logic              w_pick_any;
   logic              w_granted;
   logic              w_gnt_write;
   logic              w_accept;
   logic              w_release;
   logic [DATA_W-1:0] w_req_data [NUM_REQ];

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign w_req_data[gi] = i_req_writedata[gi*DATA_W +: DATA_W];
   end

   m2s_rr_picker #(
      .NUM_REQ (NUM_REQ),
      .ID_W    (ID_W)
   ) u_picker (
      .i_req (i_req_write),
      .i_ptr (r_rr_ptr),
      .o_idx (w_pick_idx),
      .o_any (w_pick_any)
   );

   // Reset blocks the data path in the same cycle so a mid-burst reset never leaks a write.
   assign w_granted   = (r_state == GRANTED) && !i_reset;
   assign w_gnt_write = i_req_write[r_grant_id];
   assign w_accept    = w_granted && w_gnt_write && !i_fifo_waitrequest;
   assign w_release   = w_granted &&
                        (!w_gnt_write || (w_accept && (r_burst_cnt == CNT_W'(BURST_MAX - 1))));

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt       = r_state;
      o_req_waitrequest = '1;
      o_fifo_write      = 1'b0;
      o_fifo_writedata  = '0;
      case (r_state)
         IDLE: begin
            if (w_pick_any) begin
               w_state_nxt = GRANTED;
            end
         end
         GRANTED: begin
            if (w_granted) begin
               o_fifo_write                  = w_gnt_write;
               o_fifo_writedata              = w_req_data[r_grant_id];
               o_req_waitrequest[r_grant_id] = i_fifo_waitrequest;
            end
            if (w_release) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_grant_id  <= '0;
         r_rr_ptr    <= '0;
         r_burst_cnt <= '0;
      end else begin
         if ((r_state == IDLE) && w_pick_any) begin
            r_grant_id  <= w_pick_idx;
            r_burst_cnt <= '0;
         end else if (w_accept) begin
            r_burst_cnt <= r_burst_cnt + CNT_W'(1);
         end
         // Released master drops to lowest priority for the next arbitration.
         if (w_release) begin
            r_rr_ptr <= (r_grant_id == ID_W'(NUM_REQ - 1)) ? '0 : r_grant_id + ID_W'(1);
         end
      end
   end

   assign o_fifo_address = 1'b0;
   assign o_grant_valid  = w_granted;
   assign o_grant_id     = r_grant_id;

endmodule

// File: tb/tb_m2s_fifo_write_arbiter.sv
// Randomised and directed bench for m2s_fifo_write_arbiter with a queue-based
// reference model and a negedge monitor that checks per-cycle outputs and FIFO words.
module tb_m2s_fifo_write_arbiter;

   localparam int N  = 2;
   localparam int DW = 32;
   localparam int BM = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  req_write = '0;
   logic [N*DW-1:0] req_wdata = '0;
   logic          fifo_wait = 1'b0;
   logic [N-1:0]  req_waitreq;
   logic          fifo_addr;
   logic          fifo_write;
   logic [DW-1:0] fifo_wdata;
   logic          grant_valid;
   logic [0:0]    grant_id;

   always #5 clk = ~clk;

   m2s_fifo_write_arbiter #(
      .NUM_REQ   (N),
      .DATA_W    (DW),
      .BURST_MAX (BM)
   ) dut (
      .i_clock            (clk),
      .i_reset            (rst),
      .i_req_write        (req_write),
      .i_req_writedata    (req_wdata),
      .o_req_waitrequest  (req_waitreq),
      .o_fifo_address     (fifo_addr),
      .o_fifo_write       (fifo_write),
      .o_fifo_writedata   (fifo_wdata),
      .i_fifo_waitrequest (fifo_wait),
      .o_grant_valid      (grant_valid),
      .o_grant_id         (grant_id)
   );

   typedef struct {
      logic          gv;
      int            gid;
      logic [N-1:0]  wr;
      logic          fw;
      logic [DW-1:0] fd;
   } cyc_exp_t;

   cyc_exp_t      cyc_q[$];
   logic [DW-1:0] data_q[$];
   logic [DW-1:0] mq [N][$];
   logic [N-1:0]  want = '0;
   cyc_exp_t      mon_e;

   // Reference model: current owner (-1 when none), words this grant, next priority start.
   int m_owner = -1;
   int m_cnt   = 0;
   int m_ptr   = 0;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
      end
   endtask

   task automatic step(input logic r, input logic fw);
      cyc_exp_t e;
      int g;
      @(posedge clk);
      #1;
      rst       = r;
      fifo_wait = fw;
      for (int i = 0; i < N; i++) begin
         req_write[i] = want[i] && (mq[i].size() > 0);
         req_wdata[i*DW +: DW] = (mq[i].size() > 0) ? mq[i][0] : DW'($urandom);
      end
      e.gv  = 1'b0;
      e.gid = 0;
      e.wr  = '1;
      e.fw  = 1'b0;
      e.fd  = '0;
      if (r) begin
         m_owner = -1;
         m_ptr   = 0;
         m_cnt   = 0;
      end else if (m_owner < 0) begin
         for (int k = 0; k < N; k++) begin
            int idx = (m_ptr + k) % N;
            if (m_owner < 0 && req_write[idx]) m_owner = idx;
         end
         m_cnt = 0;
      end else begin
         g       = m_owner;
         e.gv    = 1'b1;
         e.gid   = g;
         e.fw    = req_write[g];
         e.fd    = req_wdata[g*DW +: DW];
         e.wr[g] = fw;
         if (req_write[g] && !fw) begin
            data_q.push_back(e.fd);
            void'(mq[g].pop_front());
            m_cnt++;
         end
         if (!req_write[g] || m_cnt == BM) begin
            m_ptr   = (g + 1) % N;
            m_owner = -1;
         end
      end
      cyc_q.push_back(e);
   endtask

   always @(negedge clk) begin
      if (cyc_q.size() > 0) begin
         mon_e = cyc_q.pop_front();
         check("grant_valid", 64'(grant_valid), 64'(mon_e.gv));
         if (mon_e.gv) check("grant_id", 64'(grant_id), 64'(mon_e.gid));
         check("req_waitrequest", 64'(req_waitreq), 64'(mon_e.wr));
         check("fifo_write", 64'(fifo_write), 64'(mon_e.fw));
         if (mon_e.fw) check("fifo_writedata", 64'(fifo_wdata), 64'(mon_e.fd));
         check("fifo_address", 64'(fifo_addr), 64'(0));
         if (fifo_write === 1'b1 && fifo_wait === 1'b0) begin
            if (data_q.size() == 0) check("accept_without_expected_word", 64'(fifo_write), 64'(0));
            else check("fifo_word", 64'(fifo_wdata), 64'(data_q.pop_front()));
         end
      end
   end

   initial begin
      repeat (3) step(1'b1, 1'b0);

      // Single requester, 20 words -> grants of 8, 8, 4.
      for (int w = 0; w < 20; w++) mq[0].push_back(32'h100 + w);
      want = 2'b01;
      repeat (30) step(1'b0, 1'b0);
      check("single_drained", 64'(data_q.size()), 64'(0));

      // Contention: both masters streaming.
      for (int w = 0; w < 24; w++) begin
         mq[0].push_back(32'h200 + w);
         mq[1].push_back(32'h300 + w);
      end
      want = 2'b11;
      repeat (60) step(1'b0, 1'b0);

      // Backpressure mid-way through req1's burst.
      for (int w = 0; w < 16; w++) begin
         mq[0].push_back(32'h400 + w);
         mq[1].push_back(32'h500 + w);
      end
      for (int c = 0; c < 40 && !(m_owner == 1 && m_cnt == 3); c++) step(1'b0, 1'b0);
      repeat (5) step(1'b0, 1'b1);
      repeat (50) step(1'b0, 1'b0);

      // Early release: req0 has only 3 words while req1 is pending.
      for (int w = 0; w < 3; w++) mq[0].push_back(32'h600 + w);
      for (int w = 0; w < 4; w++) mq[1].push_back(32'h700 + w);
      repeat (20) step(1'b0, 1'b0);

      // Reset after 4 accepted words of req1, then both request.
      for (int w = 0; w < 16; w++) begin
         mq[0].push_back(32'h800 + w);
         mq[1].push_back(32'h900 + w);
      end
      want = 2'b10;
      for (int c = 0; c < 40 && !(m_owner == 1 && m_cnt == 4); c++) step(1'b0, 1'b0);
      want = 2'b11;
      repeat (2) step(1'b1, 1'b0);
      repeat (50) step(1'b0, 1'b0);

      // Idle.
      want = 2'b00;
      repeat (50) step(1'b0, 1'b0);

      // Randomised traffic, backpressure and occasional reset.
      for (int c = 0; c < 1500; c++) begin
         for (int i = 0; i < N; i++)
            if (mq[i].size() < 4) mq[i].push_back($urandom);
         if ($urandom_range(0, 7) == 0) want = N'($urandom);
         step(($urandom_range(0, 96) == 0), ($urandom_range(0, 3) == 0));
      end

      want = 2'b00;
      repeat (5) step(1'b0, 1'b0);
      @(negedge clk);
      #1;
      check("scoreboard_drained", 64'(data_q.size()), 64'(0));
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
